// File: rtl/router_pkg.sv
// Definitions shared by the router datapath blocks: default byte width,
// destination address encodings and header field positions.
package router_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [1:0] ADDR_0       = 2'b00;
  localparam logic [1:0] ADDR_1       = 2'b01;
  localparam logic [1:0] ADDR_2       = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = 7;

  typedef struct packed {
    logic [LEN_MSB-LEN_LSB:0]   len;
    logic [ADDR_MSB-ADDR_LSB:0] addr;
  } header_t;

endpackage

// File: rtl/router_reg_if.sv
// Control-strobe and byte-stream bundle between router_fsm, the source and
// the router_reg datapath stage.
interface router_reg_if
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
);
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  lfd_state;
  logic                  rst_int_reg;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
           full_state, lfd_state, rst_int_reg,
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
           full_state, lfd_state, rst_int_reg,
    output parity_done, low_pkt_valid, err, dout
  );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload, captured packet parity byte,
// and the sticky parity-error flag.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  acc_hdr,
  input  logic [DATA_WIDTH-1:0] hdr_byte,
  input  logic                  acc_data,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  capture,
  input  logic                  parity_done,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] int_parity;
  logic [DATA_WIDTH-1:0] pkt_parity;
  logic                  done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_parity <= '0;
    end else if (clr) begin
      int_parity <= '0;
    end else if (acc_hdr) begin
      int_parity <= int_parity ^ hdr_byte;
    end else if (acc_data) begin
      int_parity <= int_parity ^ data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_parity <= '0;
    end else if (clr) begin
      pkt_parity <= '0;
    end else if (capture) begin
      pkt_parity <= data_in;
    end
  end

  // Compare once, on the first cycle parity_done is seen high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_d <= 1'b0;
      err    <= 1'b0;
    end else if (clr) begin
      done_d <= 1'b0;
      err    <= 1'b0;
    end else begin
      done_d <= parity_done;
      if (parity_done && !done_d) begin
        err <= (int_parity != pkt_parity);
      end
    end
  end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header/hold capture, FIFO write byte mux,
// parity-capture and low_pkt_valid feedback to router_fsm.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input logic         clock,
  input logic         reset,
  router_reg_if.slave bus
);

  logic [DATA_WIDTH-1:0] header_byte;
  logic [DATA_WIDTH-1:0] hold_byte;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  parity_done_q;
  logic                  low_pkt_valid_q;
  logic                  parity_evt;
  logic                  acc_data;
  logic                  hdr_ok;

  assign hdr_ok     = bus.data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID;
  assign parity_evt = (bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                      (bus.laf_state && low_pkt_valid_q && !parity_done_q);
  // A byte stalled by fifo_full is counted here, never again on laf replay.
  assign acc_data   = bus.ld_state && bus.pkt_valid && !bus.full_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      header_byte <= '0;
    end else if (bus.detect_add && bus.pkt_valid && hdr_ok) begin
      header_byte <= bus.data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_byte <= '0;
    end else if (bus.ld_state && bus.fifo_full) begin
      hold_byte <= bus.data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else if (bus.lfd_state) begin
      dout_q <= header_byte;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_q <= bus.data_in;
    end else if (bus.laf_state) begin
      dout_q <= hold_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_done_q <= 1'b0;
    end else if (bus.detect_add) begin
      parity_done_q <= 1'b0;
    end else if (parity_evt) begin
      parity_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low_pkt_valid_q <= 1'b0;
    end else if (bus.rst_int_reg) begin
      low_pkt_valid_q <= 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid) begin
      low_pkt_valid_q <= 1'b1;
    end
  end

  router_parity_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_acc (
    .clock       (clock),
    .reset       (reset),
    .clr         (bus.detect_add),
    .acc_hdr     (bus.lfd_state),
    .hdr_byte    (header_byte),
    .acc_data    (acc_data),
    .data_in     (bus.data_in),
    .capture     (parity_evt && !bus.detect_add),
    .parity_done (parity_done_q),
    .err         (bus.err)
  );

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: cycle vectors with hand-computed outputs,
// plus FIFO-full replay, parity-on-full and asynchronous reset sequences.
module tb_router_reg;

  localparam logic [7:0] DA  = 8'h80;
  localparam logic [7:0] LFD = 8'h40;
  localparam logic [7:0] LD  = 8'h20;
  localparam logic [7:0] LAF = 8'h10;
  localparam logic [7:0] FS  = 8'h08;
  localparam logic [7:0] RIR = 8'h04;
  localparam logic [7:0] PV  = 8'h02;
  localparam logic [7:0] FF  = 8'h01;

  typedef struct {
    logic [7:0] ctl;
    logic [7:0] din;
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];

  router_reg_if #(.DATA_WIDTH(8)) bus ();

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h want 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ctl, input logic [7:0] din);
    bus.detect_add  = ctl[7];
    bus.lfd_state   = ctl[6];
    bus.ld_state    = ctl[5];
    bus.laf_state   = ctl[4];
    bus.full_state  = ctl[3];
    bus.rst_int_reg = ctl[2];
    bus.pkt_valid   = ctl[1];
    bus.fifo_full   = ctl[0];
    bus.data_in     = din;
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v.ctl, v.din);
    @(posedge clock);
    @(negedge clock);
    chk({tag, ".dout"}, bus.dout, v.dout);
    chk({tag, ".parity_done"}, {7'd0, bus.parity_done}, {7'd0, v.pd});
    chk({tag, ".low_pkt_valid"}, {7'd0, bus.low_pkt_valid}, {7'd0, v.lpv});
    chk({tag, ".err"}, {7'd0, bus.err}, {7'd0, v.err});
  endtask

  initial begin
    // Good packet to port 1: 05 ^ A3 = A6
    tbl.push_back('{DA | PV,  8'h05, 8'h00, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{LFD | PV, 8'hA3, 8'h05, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{LD | PV,  8'hA3, 8'hA3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{LD,       8'hA6, 8'hA6, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{RIR,      8'h00, 8'hA6, 1'b1, 1'b0, 1'b0});
    // Same packet, wrong parity byte
    tbl.push_back('{DA | PV,  8'h05, 8'hA6, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{LFD | PV, 8'hA3, 8'h05, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{LD | PV,  8'hA3, 8'hA3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{LD,       8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{RIR,      8'h00, 8'h00, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{8'h00,    8'h00, 8'h00, 1'b1, 1'b0, 1'b1});
    // Invalid address: header stays 05, err cleared by detect_add
    tbl.push_back('{DA | PV,  8'h07, 8'h00, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{LFD | PV, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0});
    // Set and clear of low_pkt_valid together: clear wins
    tbl.push_back('{LD | RIR, 8'h05, 8'h05, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h00,    8'h00, 8'h05, 1'b1, 1'b0, 1'b0});

    drive(8'h00, 8'h00);
    @(negedge clock);
    @(negedge clock);
    chk("rst.dout", bus.dout, 8'h00);
    chk("rst.parity_done", {7'd0, bus.parity_done}, 8'h00);
    chk("rst.low_pkt_valid", {7'd0, bus.low_pkt_valid}, 8'h00);
    chk("rst.err", {7'd0, bus.err}, 8'h00);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // FIFO full mid-payload: 0A ^ 11 ^ 22 = 39, 22 replayed in laf
    step('{DA | PV,       8'h0A, 8'h05, 1'b0, 1'b0, 1'b0}, "full0");
    step('{LFD | PV,      8'h11, 8'h0A, 1'b0, 1'b0, 1'b0}, "full1");
    step('{LD | PV,       8'h11, 8'h11, 1'b0, 1'b0, 1'b0}, "full2");
    step('{LD | PV | FF,  8'h22, 8'h11, 1'b0, 1'b0, 1'b0}, "full3");
    chk("full.hold_byte", dut.hold_byte, 8'h22);
    step('{FS | PV | FF,  8'h22, 8'h11, 1'b0, 1'b0, 1'b0}, "full4");
    step('{FS | PV | FF,  8'h22, 8'h11, 1'b0, 1'b0, 1'b0}, "full5");
    step('{LAF | PV,      8'h22, 8'h22, 1'b0, 1'b0, 1'b0}, "full6");
    chk("full.int_parity", dut.u_parity_acc.int_parity, 8'h39);
    step('{LD,            8'h39, 8'h39, 1'b1, 1'b1, 1'b0}, "full7");
    step('{RIR,           8'h00, 8'h39, 1'b1, 1'b0, 1'b0}, "full8");

    // Parity byte arrives while full; captured in laf via low_pkt_valid
    step('{DA | PV,       8'h05, 8'h39, 1'b0, 1'b0, 1'b0}, "pfull0");
    step('{LFD | PV,      8'hA3, 8'h05, 1'b0, 1'b0, 1'b0}, "pfull1");
    step('{LD | PV,       8'hA3, 8'hA3, 1'b0, 1'b0, 1'b0}, "pfull2");
    step('{LD | FF,       8'hA6, 8'hA3, 1'b0, 1'b1, 1'b0}, "pfull3");
    step('{FS | FF,       8'hA6, 8'hA3, 1'b0, 1'b1, 1'b0}, "pfull4");
    step('{LAF,           8'hA6, 8'hA6, 1'b1, 1'b1, 1'b0}, "pfull5");
    step('{RIR,           8'h00, 8'hA6, 1'b1, 1'b0, 1'b0}, "pfull6");

    // Asynchronous reset in the middle of a clock while loading
    drive(LD, 8'h5A);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("areset.dout", bus.dout, 8'h00);
    chk("areset.parity_done", {7'd0, bus.parity_done}, 8'h00);
    chk("areset.low_pkt_valid", {7'd0, bus.low_pkt_valid}, 8'h00);
    chk("areset.err", {7'd0, bus.err}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    drive(8'h00, 8'h00);
    @(posedge clock);
    @(negedge clock);
    chk("post_reset.dout", bus.dout, 8'h00);
    chk("post_reset.parity_done", {7'd0, bus.parity_done}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 packet router, downstream of router_fsm and upstream of the three output FIFOs.
- Consumes the FSM state strobes and the raw input byte stream. Produces the FIFO write byte (dout).
- Keeps a byte aside when the destination FIFO is full.
- Accumulates running parity and flags parity errors. Feeds parity_done and low_pkt_valid back to router_fsm.

Parameters:
- DATA_WIDTH, 8, byte width of data_in and dout (header, payload and parity bytes).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pkt_valid  in  1  source byte valid; low on the parity byte
- data_in  in  DATA_WIDTH  source byte; header[1:0] = destination address, header[7:2] = payload length
- fifo_full  in  1  selected destination FIFO full
- detect_add  in  1  FSM in DECODE_ADDRESS
- ld_state  in  1  FSM in LOAD_DATA
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- full_state  in  1  FSM in FIFO_FULL_STATE
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR; clears low_pkt_valid
- parity_done  out  1  packet parity byte captured
- low_pkt_valid  out  1  pkt_valid fell while loading data
- err  out  1  parity mismatch for the current packet
- dout  out  DATA_WIDTH  byte to FIFO write port

Behaviour:
- Reset: dout=0, parity_done=0, low_pkt_valid=0, err=0. Internal header_byte, hold_byte, int_parity and pkt_parity are also 0. Reset asserted mid-packet abandons the packet; no partial output persists.
- Header capture: header_byte <= data_in when detect_add & pkt_valid & data_in[1:0]!=2'b11. Address 2'b11 is never latched.
- Hold byte: hold_byte <= data_in when ld_state & fifo_full. This captures the byte that arrived with full.
- dout is a registered mux, one cycle latency. Priority order:
  - lfd_state: dout <= header_byte.
  - ld_state & ~fifo_full: dout <= data_in.
  - laf_state: dout <= hold_byte.
  - Otherwise dout holds.
- Internal parity:
  - detect_add: int_parity <= 0.
  - lfd_state: int_parity <= int_parity ^ header_byte.
  - ld_state & pkt_valid & ~full_state: int_parity <= int_parity ^ data_in.
  - The parity byte itself (pkt_valid=0) is never accumulated.
- Parity capture event P = (ld_state & ~fifo_full & ~pkt_valid) | (laf_state & low_pkt_valid & ~parity_done).
  - On P: pkt_parity <= data_in and parity_done <= 1.
  - parity_done clears only on detect_add.
  - P and detect_add are mutually exclusive by FSM construction. If both are seen, detect_add wins.
- low_pkt_valid:
  - Set when ld_state & ~pkt_valid.
  - Clear when rst_int_reg.
  - Simultaneous set and clear: clear wins.
- err:
  - One cycle after parity_done is first high, err <= (int_parity != pkt_parity).
  - err holds until detect_add clears it.
  - err never asserts while parity_done=0.
- Full during payload: a byte arriving with fifo_full is accumulated into parity once, not twice on replay in laf_state.
- Back-to-back packets: detect_add of packet N+1 clears parity state in the same edge. No leakage between packets.

Decomposition:
- Shared package router_pkg holds:
  - DATA_WIDTH default
  - address encodings ADDR_0=2'b00, ADDR_1=2'b01, ADDR_2=2'b10, ADDR_INVALID=2'b11
  - header field slices: ADDR bits [1:0], LEN bits [7:2]
- Common with router_fsm and router_sync.
- One sub-module is natural: router_parity_acc, the XOR accumulator plus compare and err register. Everything else stays flat in router_reg.

Test Plan:
- Reset check: assert reset asynchronously mid-clock during ld_state -> all outputs 0 before next edge; dout=0 after release.
- Good packet to port 1:
  - Stimulus: detect_add with 0x05, lfd, then ld with payload 0xA3 and pkt_valid=1, then parity byte 0xA6 with pkt_valid=0.
  - Response: dout sequence 0x05, 0xA3; parity_done=1 and low_pkt_valid=1 on the same edge; err=0 one cycle later.
- Bad parity:
  - Stimulus: same packet but parity byte 0x00.
  - Response: parity_done=1, then err=1 one cycle later; err cleared on next detect_add.
- FIFO full mid-payload:
  - Stimulus: header 0x0A, payload 0x11 then 0x22 arriving with fifo_full=1; full_state 2 cycles; then laf_state.
  - Response: hold_byte=0x22; dout=0x22 in laf_state; int_parity = 0x0A^0x11^0x22 = 0x39; no double accumulation.
- Invalid address: detect_add with data_in=0x07 (addr 11) -> header_byte unchanged from previous value.
- low_pkt_valid clear: rst_int_reg=1 in the same cycle that ld_state & ~pkt_valid holds -> low_pkt_valid stays 0.
